iiitb_r4_booth_mul: RTL and testbench
=====================================

Name: iiitb_r4_booth_mul

Overview:
Parametrised radix-4 Booth sequential multiplier. It is the next generation of the team's radix-2 4-bit Booth block. It generalises operand width, adds a per-transaction signed/unsigned mode, and retires two multiplier bits per cycle. It sits on a valid/ready stream: operands come in on one handshake and the product goes out on another, with backpressure.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4 (elaboration error otherwise)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transaction valid
in_ready  output  1  block can accept operands
signed_mode  input  1  1 = operands two's complement, 0 = unsigned; sampled with operands
M  input  WIDTH  multiplicand
Q  input  WIDTH  multiplier
clear  input  1  synchronous abort; discards any in-flight or held result
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
P  output  2*WIDTH  product
busy  output  1  high while in CALC

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low on reset_n.
- Reset (reset_n=0, takes effect immediately without a clock edge):
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - P=0, internal registers=0
  - in-flight work is dropped.
- Internal extension: E=WIDTH+2, ITER=E/2.
  - Mext and Qext are WIDTH sign-extended when signed_mode=1 and zero-extended when 0, to E bits.
  - Accumulator A is E+2 bits wide (holds ±2M). Extra bit q_m1 starts at 0.
- FSM, three states:
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready: latch Mext, Qext; A=0, q_m1=0, count=ITER; go to CALC.
  - CALC:
    - in_ready=0, busy=1.
    - Each edge, decode {Qext[1],Qext[0],q_m1}:
      - 000 or 111: +0
      - 001 or 010: +M
      - 011: +2M
      - 100: -2M
      - 101 or 110: -M
    - Add the selected term to A (sign-extended, mod 2^(E+2)).
    - Arithmetic-shift {A,Qext,q_m1} right by 2. q_m1 takes the old Qext[1].
    - count decrements. On the edge where count goes 1->0, go to DONE.
    - Load P = low 2*WIDTH bits of {A,Qext} after that final shift. out_valid=1.
  - DONE:
    - out_valid=1, in_ready=0. P is held stable while out_valid&!out_ready.
    - On out_valid&out_ready: out_valid=0, go to IDLE. P retains its value.
    - No new operand is accepted in the same cycle; one idle cycle occurs between transactions.
- Latency: operands accepted at edge t0. Booth steps occur at edges t0+1..t0+ITER. out_valid rises after edge t0+ITER. For WIDTH=8, ITER=5.
- Result rule:
  - P equals the exact mathematical product of M and Q under the sampled mode.
  - This always fits in 2*WIDTH bits: signed result as two's complement, unsigned as binary.
- clear=1 at an edge, in any state:
  - go to IDLE; out_valid=0, busy=0, in_ready=1; P unchanged.
  - A concurrent in_valid is ignored that cycle.
  - clear has priority over all handshakes. reset_n has priority over clear.
- Inputs M, Q, signed_mode are ignored outside the accepting cycle. Changes during CALC/DONE do not affect the result.
- in_valid with in_ready=0 is a no-op; the producer must hold.
- No X propagation: every register is reset.

Test Plan:
- Reset: assert reset_n=0 mid-CALC, asynchronously between edges -> immediately out_valid=0, busy=0, in_ready=1, P=0. After release, a new transaction computes correctly.
- Unsigned corner, WIDTH=8: M=255, Q=255, signed_mode=0 -> after 5 edges out_valid=1, P=16'hFE01.
- Signed corners, WIDTH=8, signed_mode=1:
  - M=-128, Q=-128 -> P=16'h4000
  - M=-7, Q=5 -> P=16'hFFDD
  - M=127, Q=-128 -> P=16'hC080
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Toggle M/Q/in_valid during the wait -> P stable, in_ready=0. Raise out_ready -> one-cycle handshake, then in_ready=1.
- clear: assert during the 3rd CALC cycle -> next cycle IDLE, out_valid never asserts. The following transaction M=12, Q=-3, signed -> P=16'hFFDC.
- Random regression, WIDTH=4, 8, 16: 10k random transactions with random mode and random out_ready stalls -> P matches the reference product every time. Latency is exactly ITER edges from accept to out_valid.

Source files
------------

// File: rtl/iiitb_r4_booth_mul.sv
// ============================================================================
// Module   : iiitb_r4_booth_mul
// Brief    : Radix-4 Booth sequential multiplier, signed/unsigned, valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iiitb_r4_booth_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   M,
    input  logic [WIDTH-1:0]   Q,
    input  logic               clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);

    localparam int E    = WIDTH + 2;
    localparam int ITER = E / 2;
    localparam int CW   = $clog2(ITER + 1);

    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_width_check
            $error("iiitb_r4_booth_mul: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [E-1:0]    m_ext;
    logic [E-1:0]    q_reg;
    logic [E+1:0]    a_reg;
    logic            q_m1;
    logic [CW-1:0]   count;

    logic [E-1:0]    m_in_ext;
    logic [E-1:0]    q_in_ext;
    logic [E+1:0]    m_wide;
    logic [E+1:0]    term;
    logic [E+1:0]    sum;
    logic [E+1:0]    a_next;
    logic [E-1:0]    q_next;

    // Unsigned operands get two zero bits on top so the Booth recoding sees them as positive.
    assign m_in_ext = {{2{signed_mode & M[WIDTH-1]}}, M};
    assign q_in_ext = {{2{signed_mode & Q[WIDTH-1]}}, Q};

    always_comb begin
        m_wide = {{2{m_ext[E-1]}}, m_ext};
        case ({q_reg[1:0], q_m1})
            3'b001, 3'b010: term = m_wide;
            3'b011:         term = m_wide << 1;
            3'b100:         term = -(m_wide << 1);
            3'b101, 3'b110: term = -m_wide;
            default:        term = '0;
        endcase
        sum    = a_reg + term;
        a_next = {{2{sum[E+1]}}, sum[E+1:2]};
        q_next = {sum[1:0], q_reg[E-1:2]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            P         <= '0;
            m_ext     <= '0;
            q_reg     <= '0;
            a_reg     <= '0;
            q_m1      <= 1'b0;
            count     <= '0;
        end else if (clear) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_ext    <= m_in_ext;
                        q_reg    <= q_in_ext;
                        a_reg    <= '0;
                        q_m1     <= 1'b0;
                        count    <= CW'(ITER);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    q_m1  <= q_reg[1];
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        // Product is the low 2*WIDTH bits of {A,Q} after the last shift.
                        P         <= {a_next[2*WIDTH-E-1:0], q_next};
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iiitb_r4_booth_mul.sv
// ============================================================================
// Module   : tb_iiitb_r4_booth_mul
// Brief    : Self-checking bench for iiitb_r4_booth_mul (WIDTH=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iiitb_r4_booth_mul;

    localparam int WIDTH = 8;
    localparam int ITER  = (WIDTH + 2) / 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic              signed_mode;
    logic [WIDTH-1:0]  M;
    logic [WIDTH-1:0]  Q;
    logic              clear;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [2*WIDTH-1:0] P;
    logic              busy;

    iiitb_r4_booth_mul #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .signed_mode(signed_mode), .M(M), .Q(Q), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .P(P), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] m; logic [7:0] q; logic sm; logic [15:0] p; } vec_t;
    typedef struct { logic [15:0] p; int t0; } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   or_mode = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready: 0 = always ready, 1 = random stalls, 2 = held low
    always @(posedge clk) begin
        #2;
        if (or_mode == 0)      out_ready = 1'b1;
        else if (or_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
        else                   out_ready = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] m, input logic [7:0] q, input logic sm);
        int a, b;
        logic [31:0] r;
        a = sm ? int'($signed(m)) : int'(m);
        b = sm ? int'($signed(q)) : int'(q);
        r = a * b;
        return r[15:0];
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
                else                check("latency", cyc, sb[0].t0 + ITER);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("product", {16'd0, P}, {16'd0, e.p});
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [7:0] m, input logic [7:0] q, input logic sm,
                        input logic [15:0] exp, input logic track);
        int guard;
        @(posedge clk); #1;
        M = m; Q = q; signed_mode = sm; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (track) sb.push_back('{exp, cyc + 1});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb.size() > 0 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        check("drain", sb.size(), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        logic [15:0] hold_p;
        logic        seen_ov;
        int          g;

        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
        vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
        vecs.push_back('{8'hF9, 8'h05, 1'b1, 16'hFFDD});
        vecs.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080});
        vecs.push_back('{8'h0C, 8'hFD, 1'b1, 16'hFFDC});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 16'h0000});
        vecs.push_back('{8'h80, 8'h02, 1'b0, 16'h0100});
        vecs.push_back('{8'hFF, 8'h80, 1'b1, 16'h0080});
        vecs.push_back('{8'h64, 8'hC8, 1'b0, 16'h4E20});

        reset_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
        M = '0; Q = '0; signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_P", {16'd0, P}, 32'd0);
        reset_n = 1'b1;

        // table vectors, no backpressure
        for (int i = 0; i < vecs.size(); i++)
            send(vecs[i].m, vecs[i].q, vecs[i].sm, vecs[i].p, 1'b1);
        wait_drain();

        // backpressure: output held for 10 cycles while inputs wiggle
        or_mode = 2;
        send(8'd13, 8'd11, 1'b0, 16'h008F, 1'b1);
        g = 0;
        @(negedge clk);
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("bp_out_valid_rise", {31'd0, out_valid}, 32'd1);
        hold_p = P;
        check("bp_P_value", {16'd0, hold_p}, 32'h008F);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            M = 8'($urandom); Q = 8'($urandom); in_valid = 1'($urandom);
            @(negedge clk);
            check("bp_P_stable", {16'd0, P}, {16'd0, hold_p});
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        or_mode = 0;
        @(posedge clk); #1;
        check("bp_out_valid_drop", {31'd0, out_valid}, 32'd0);
        check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
        check("bp_P_retained", {16'd0, P}, {16'd0, hold_p});
        wait_drain();

        // clear during the third CALC cycle
        @(posedge clk); #1;
        check("clr_pre_ready", {31'd0, in_ready}, 32'd1);
        M = 8'd77; Q = 8'd99; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("clr_busy_calc", {31'd0, busy}, 32'd1);
        @(posedge clk);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_in_ready", {31'd0, in_ready}, 32'd1);
        seen_ov = 1'b0;
        for (int i = 0; i < ITER + 4; i++) begin
            @(negedge clk);
            if (out_valid) seen_ov = 1'b1;
        end
        check("clr_no_out_valid", {31'd0, seen_ov}, 32'd0);
        send(8'h0C, 8'hFD, 1'b1, 16'hFFDC, 1'b1);
        wait_drain();

        // random regression with random stalls
        or_mode = 1;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] rm, rq;
            logic       rs;
            rm = 8'($urandom); rq = 8'($urandom); rs = 1'($urandom);
            send(rm, rq, rs, ref_prod(rm, rq, rs), 1'b1);
        end
        wait_drain();
        or_mode = 0;
        repeat (2) @(posedge clk);

        // asynchronous reset mid-CALC, between edges
        @(posedge clk); #1;
        M = 8'd200; Q = 8'd201; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_P", {16'd0, P}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        send(8'hF9, 8'h05, 1'b1, 16'hFFDD, 1'b1);
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
